// File: rtl/button_press_classifier_if.sv
// Interface: button_press_classifier_if
// Purpose : Bundles the filtered button level and the classified event outputs
//           of button_press_classifier.
// Signals :
//   btn_stable    filtered button level, 1 = pressed
//   press_pulse   1-cycle pulse on press detection
//   short_press   1-cycle pulse on release before the long threshold
//   long_press    1-cycle pulse when the long threshold is reached
//   repeat_pulse  1-cycle pulse every repeat period while long-held
//   release_pulse 1-cycle pulse on any release
//   held          level, 1 while the button is long-held
//   event_count   running count of short + long events, wraps modulo 256
// Modports:
//   master - the button filter / consumer side (drives btn_stable)
//   slave  - the classifier itself (drives the events)
interface button_press_classifier_if;
  logic       btn_stable;
  logic       press_pulse;
  logic       short_press;
  logic       long_press;
  logic       repeat_pulse;
  logic       release_pulse;
  logic       held;
  logic [7:0] event_count;

  modport master (
    output btn_stable,
    input  press_pulse, short_press, long_press, repeat_pulse,
           release_pulse, held, event_count
  );

  modport slave (
    input  btn_stable,
    output press_pulse, short_press, long_press, repeat_pulse,
           release_pulse, held, event_count
  );
endinterface

// File: rtl/button_press_classifier.sv
// Module : button_press_classifier
// Purpose: Turns the filtered push-button level into press, short press,
//          long press, auto-repeat and release events. All outputs are
//          registered, so every event appears in the cycle after the clock
//          edge that sampled the deciding btn_stable value.
// Ports  :
//   clk   in  system clock, rising edge
//   rstn  in  asynchronous active-low reset
//   bus   slave modport of button_press_classifier_if (btn_stable in,
//         event pulses / held / event_count out)
// Parameters:
//   LONG_CYCLES   high samples after press entry that make a long press (>=2)
//   REPEAT_CYCLES cycles between repeat pulses once long-held (>=2)
//   CNT_W         width of the duration counters, must hold LONG_CYCLES
module button_press_classifier #(
  parameter int LONG_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000,
  parameter int CNT_W         = 25
) (
  input  logic                        clk,
  input  logic                        rstn,
  button_press_classifier_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_LONG_HELD
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic [7:0]       event_count_q, event_count_d;
  logic             press_q, press_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             release_q, release_d;
  logic             held_q, held_d;

  // Next-state logic. Pulse outputs are computed here from the current sample
  // and registered below, so they last exactly one cycle.
  always_comb begin
    state_d       = state_q;
    dcnt_d        = dcnt_q;
    rcnt_d        = rcnt_q;
    event_count_d = event_count_q;
    press_d       = 1'b0;
    short_d       = 1'b0;
    long_d        = 1'b0;
    repeat_d      = 1'b0;
    release_d     = 1'b0;
    held_d        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.btn_stable) begin
          state_d = ST_PRESSED;
          dcnt_d  = '0;
          press_d = 1'b1;
        end
      end

      ST_PRESSED: begin
        if (!bus.btn_stable) begin
          state_d       = ST_IDLE;
          dcnt_d        = '0;
          short_d       = 1'b1;
          release_d     = 1'b1;
          event_count_d = event_count_q + 8'd1;
        end else if (dcnt_q == LONG_LAST) begin
          // dcnt lags the edge index by one, so this fires after
          // LONG_CYCLES+1 high samples including the entry sample.
          state_d       = ST_LONG_HELD;
          dcnt_d        = '0;
          rcnt_d        = '0;
          long_d        = 1'b1;
          held_d        = 1'b1;
          event_count_d = event_count_q + 8'd1;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end

      ST_LONG_HELD: begin
        if (!bus.btn_stable) begin
          state_d   = ST_IDLE;
          rcnt_d    = '0;
          release_d = 1'b1;
        end else begin
          held_d = 1'b1;
          if (rcnt_q == REPEAT_LAST) begin
            repeat_d = 1'b1;
            rcnt_d   = '0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        dcnt_d  = '0;
        rcnt_d  = '0;
      end
    endcase
  end

  // State, counters and registered outputs; reset drops everything at once,
  // including mid-press, without producing a release event.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      dcnt_q        <= '0;
      rcnt_q        <= '0;
      event_count_q <= '0;
      press_q       <= 1'b0;
      short_q       <= 1'b0;
      long_q        <= 1'b0;
      repeat_q      <= 1'b0;
      release_q     <= 1'b0;
      held_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      dcnt_q        <= dcnt_d;
      rcnt_q        <= rcnt_d;
      event_count_q <= event_count_d;
      press_q       <= press_d;
      short_q       <= short_d;
      long_q        <= long_d;
      repeat_q      <= repeat_d;
      release_q     <= release_d;
      held_q        <= held_d;
    end
  end

  assign bus.press_pulse   = press_q;
  assign bus.short_press   = short_q;
  assign bus.long_press    = long_q;
  assign bus.repeat_pulse  = repeat_q;
  assign bus.release_pulse = release_q;
  assign bus.held          = held_q;
  assign bus.event_count   = event_count_q;

endmodule

// File: tb/tb_button_press_classifier.sv
// Testbench for button_press_classifier with LONG_CYCLES=8, REPEAT_CYCLES=4.
// Each step drives one btn_stable sample, lets one rising edge take it and
// then looks at the registered outputs 1 ns later.
module tb_button_press_classifier;

  localparam int LONG_CYCLES   = 8;
  localparam int REPEAT_CYCLES = 4;

  logic clk;
  logic rstn;

  button_press_classifier_if bif();

  button_press_classifier #(
    .LONG_CYCLES   (LONG_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES),
    .CNT_W         (25)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Running tallies of pulses seen by step(), cleared by do_reset().
  int cnt_press   = 0;
  int cnt_short   = 0;
  int cnt_long    = 0;
  int cnt_repeat  = 0;
  int cnt_release = 0;

  task automatic step(input logic b);
    bif.btn_stable = b;
    @(posedge clk);
    #1;
    if (bif.press_pulse)   cnt_press++;
    if (bif.short_press)   cnt_short++;
    if (bif.long_press)    cnt_long++;
    if (bif.repeat_pulse)  cnt_repeat++;
    if (bif.release_pulse) cnt_release++;
  endtask

  task automatic clear_tallies();
    cnt_press   = 0;
    cnt_short   = 0;
    cnt_long    = 0;
    cnt_repeat  = 0;
    cnt_release = 0;
  endtask

  task automatic do_reset();
    bif.btn_stable = 1'b0;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    clear_tallies();
  endtask

  // Reset held with the button pressed, then release reset with it still high.
  task automatic test_reset();
    logic [13:0] outs;
    rstn = 1'b0;
    bif.btn_stable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    outs = {bif.press_pulse, bif.short_press, bif.long_press, bif.repeat_pulse,
            bif.release_pulse, bif.held, bif.event_count};
    tests_run++;
    if (outs !== 14'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got %b expected all zero", outs);
    end
    rstn = 1'b1;
    clear_tallies();
    step(1'b1);
    tests_run++;
    if (bif.press_pulse !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_first_press: press_pulse=%b expected 1", bif.press_pulse);
    end
    step(1'b1);
    tests_run++;
    if (bif.press_pulse !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL press_width: press_pulse=%b expected 0", bif.press_pulse);
    end
    step(1'b0);
    tests_run++;
    if ({bif.short_press, bif.release_pulse, bif.event_count} !== {2'b11, 8'd1}) begin
      tests_failed++;
      $display("[TB] FAIL reset_then_release: short=%b rel=%b cnt=%0d expected 1 1 1",
               bif.short_press, bif.release_pulse, bif.event_count);
    end
  endtask

  // Three high samples then low: short press three cycles after press_pulse.
  task automatic test_short_press();
    do_reset();
    step(1'b1);
    tests_run++;
    if (bif.press_pulse !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL short_press_pulse: press_pulse=%b expected 1", bif.press_pulse);
    end
    step(1'b1);
    step(1'b1);
    tests_run++;
    if (cnt_short !== 0) begin
      tests_failed++;
      $display("[TB] FAIL short_early: short count %0d expected 0", cnt_short);
    end
    step(1'b0);
    tests_run++;
    if ({bif.short_press, bif.release_pulse, bif.long_press} !== 3'b110) begin
      tests_failed++;
      $display("[TB] FAIL short_event: short=%b rel=%b long=%b expected 1 1 0",
               bif.short_press, bif.release_pulse, bif.long_press);
    end
    tests_run++;
    if (bif.event_count !== 8'd1) begin
      tests_failed++;
      $display("[TB] FAIL short_count: event_count=%0d expected 1", bif.event_count);
    end
    step(1'b0);
    step(1'b0);
    tests_run++;
    if ({cnt_short, cnt_release, cnt_long} !== {32'd1, 32'd1, 32'd0}) begin
      tests_failed++;
      $display("[TB] FAIL short_width: short=%0d rel=%0d long=%0d expected 1 1 0",
               cnt_short, cnt_release, cnt_long);
    end
  endtask

  // 8 high samples stays short, 9 high samples reaches long.
  task automatic test_long_boundary();
    do_reset();
    repeat (LONG_CYCLES) step(1'b1);
    step(1'b0);
    tests_run++;
    if ({cnt_short, cnt_long} !== {32'd1, 32'd0}) begin
      tests_failed++;
      $display("[TB] FAIL eight_samples: short=%0d long=%0d expected 1 0", cnt_short, cnt_long);
    end
    repeat (LONG_CYCLES) step(1'b1);
    tests_run++;
    if (bif.long_press !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL long_early: long_press=%b expected 0", bif.long_press);
    end
    step(1'b1);
    tests_run++;
    if ({bif.long_press, bif.held} !== 2'b11) begin
      tests_failed++;
      $display("[TB] FAIL nine_samples: long=%b held=%b expected 1 1", bif.long_press, bif.held);
    end
    step(1'b1);
    step(1'b1);
    tests_run++;
    if ({bif.held, bif.long_press, cnt_repeat} !== {2'b10, 32'd0}) begin
      tests_failed++;
      $display("[TB] FAIL held_level: held=%b long=%b repeats=%0d expected 1 0 0",
               bif.held, bif.long_press, cnt_repeat);
    end
    step(1'b0);
    tests_run++;
    if ({bif.release_pulse, bif.held, bif.short_press} !== 3'b100) begin
      tests_failed++;
      $display("[TB] FAIL long_release: rel=%b held=%b short=%b expected 1 0 0",
               bif.release_pulse, bif.held, bif.short_press);
    end
    tests_run++;
    if (bif.event_count !== 8'd2) begin
      tests_failed++;
      $display("[TB] FAIL long_count: event_count=%0d expected 2", bif.event_count);
    end
  endtask

  // Long press then 12 more held samples: repeats at +4, +8, +12 edges.
  task automatic test_repeat();
    logic exp_rep;
    do_reset();
    repeat (LONG_CYCLES + 1) step(1'b1);
    tests_run++;
    if (bif.long_press !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL repeat_entry: long_press=%b expected 1", bif.long_press);
    end
    for (int i = 1; i <= 12; i++) begin
      step(1'b1);
      exp_rep = ((i % REPEAT_CYCLES) == 0);
      tests_run++;
      if (bif.repeat_pulse !== exp_rep) begin
        tests_failed++;
        $display("[TB] FAIL repeat_edge_%0d: repeat_pulse=%b expected %b", i, bif.repeat_pulse, exp_rep);
      end
    end
    step(1'b0);
    tests_run++;
    if ({bif.release_pulse, bif.repeat_pulse, bif.event_count} !== {2'b10, 8'd1}) begin
      tests_failed++;
      $display("[TB] FAIL repeat_release: rel=%b rep=%b cnt=%0d expected 1 0 1",
               bif.release_pulse, bif.repeat_pulse, bif.event_count);
    end
    tests_run++;
    if ({cnt_long, cnt_repeat, cnt_short} !== {32'd1, 32'd3, 32'd0}) begin
      tests_failed++;
      $display("[TB] FAIL repeat_totals: long=%0d rep=%0d short=%0d expected 1 3 0",
               cnt_long, cnt_repeat, cnt_short);
    end
  endtask

  // Reset mid-LONG_HELD drops everything immediately with no release event.
  task automatic test_reset_mid_held();
    do_reset();
    repeat (LONG_CYCLES + 3) step(1'b1);
    tests_run++;
    if ({bif.held, bif.event_count} !== {1'b1, 8'd1}) begin
      tests_failed++;
      $display("[TB] FAIL pre_reset_held: held=%b cnt=%0d expected 1 1", bif.held, bif.event_count);
    end
    #2;
    rstn = 1'b0;
    #1;
    tests_run++;
    if ({bif.held, bif.press_pulse, bif.short_press, bif.long_press, bif.repeat_pulse,
         bif.release_pulse, bif.event_count} !== 14'd0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset: held=%b rel=%b cnt=%0d expected 0 0 0",
               bif.held, bif.release_pulse, bif.event_count);
    end
    step(1'b1);
    step(1'b0);
    tests_run++;
    if (cnt_release !== 0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_release: release count %0d expected 0", cnt_release);
    end
    rstn = 1'b1;
  endtask

  // 256 back-to-back short presses separated by a single low sample.
  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 255; i++) begin
      step(1'b1);
      step(1'b0);
    end
    tests_run++;
    if (bif.event_count !== 8'd255) begin
      tests_failed++;
      $display("[TB] FAIL count_255: event_count=%0d expected 255", bif.event_count);
    end
    step(1'b1);
    step(1'b0);
    tests_run++;
    if (bif.event_count !== 8'd0) begin
      tests_failed++;
      $display("[TB] FAIL count_wrap: event_count=%0d expected 0", bif.event_count);
    end
    tests_run++;
    if ({cnt_press, cnt_short, cnt_release} !== {32'd256, 32'd256, 32'd256}) begin
      tests_failed++;
      $display("[TB] FAIL back_to_back: press=%0d short=%0d rel=%0d expected 256 each",
               cnt_press, cnt_short, cnt_release);
    end
  endtask

  initial begin
    rstn = 1'b0;
    bif.btn_stable = 1'b0;
    test_reset();
    test_short_press();
    test_long_boundary();
    test_repeat();
    test_reset_mid_held();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
